uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Oversampling UART receiver. It is the receive-side counterpart of the team's UART transmitter: same frame format and parity options.
- Frame format: start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit (1).
- Recovers bits by majority-vote oversampling, deserializes them, checks parity and stop, and presents one parallel word per frame with a single-cycle valid strobe.
- Sits between the RX pad and the system register/FIFO layer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the PRESCALE input. Supported oversampling ratios: 8, 16, 32.

Ports:
- CLK  in  1  oversampling clock. Frequency = PRESCALE x baud.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line. Idle level is 1.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- PRESCALE  in  PRESCALE_WIDTH  oversampling ratio. Legal values: 8, 16, 32.
- P_DATA  out  DATA_WIDTH  last good received word.
- data_valid  out  1  one-cycle pulse when P_DATA is updated.
- par_err  out  1  one-cycle pulse on parity mismatch.
- stp_err  out  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Reset: all outputs 0, P_DATA = 0, state IDLE, all counters 0. Reset asserted mid-frame aborts the frame; no strobes are produced.
- Config capture: PAR_EN, PAR_TYP and PRESCALE (P) are captured on the cycle the start edge is detected. Changes during a frame are ignored.
- Counters:
  - edge_cnt runs 0..P-1 inside each bit and wraps to 0.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, valid from edge_cnt = P/2+2.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when RX_IN = 0, go to START. That cycle counts as edge_cnt = 0 of the start bit.
- START: at edge_cnt = P-1:
  - sampled bit 1 (glitch) -> IDLE, no strobe;
  - sampled bit 0 -> DATA, bit_cnt = 0.
- DATA:
  - Each sampled bit is shifted in LSB-first.
  - At edge_cnt = P-1 with bit_cnt = DATA_WIDTH-1, go to PARITY if PAR_EN = 1, otherwise STOP.
- PARITY:
  - Expected parity bit = XOR of the data bits, inverted when PAR_TYP = 1.
  - The mismatch flag is held until the end of the frame.
  - Go to STOP at edge_cnt = P-1.
- STOP, at edge_cnt = P-1:
  - stp_err_int = (sampled bit == 0).
  - Next cycle:
    - no errors -> P_DATA <= shift register, data_valid = 1;
    - parity error -> par_err = 1;
    - stop error -> stp_err = 1;
    - both errors -> par_err = 1 and stp_err = 1.
  - P_DATA holds its old value on any error.
- Strobes are high for exactly one cycle.
- Frame end:
  - At the end of STOP, if RX_IN = 0, go directly to START with edge_cnt = 0 (back-to-back frames).
  - Otherwise go to IDLE.
- Latency: from the start-edge cycle (call it cycle 0), the strobe is asserted in cycle (10 + PAR_EN) x P, for DATA_WIDTH = 8.
- A break condition (RX_IN stuck at 0) gives stp_err once per frame time, repeating.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset value 1, before any logic. All latencies grow by 2 cycles.
- Undefined: RX_IN is used directly and must already be synchronous to CLK.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 -> P_DATA = 0xA5; data_valid is a single pulse at cycle 80; par_err = stp_err = 0.
- P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 -> P_DATA = 0x3C, data_valid at cycle 176. Repeat with parity bit 1 -> par_err pulse, P_DATA stays 0x3C from the previous frame, no data_valid.
- P=8, frame 0x0F with stop bit 0 -> stp_err pulse at cycle 80; P_DATA unchanged.
- P=16, RX_IN low for 3 cycles then high -> returns to IDLE, no strobes. A single-cycle low spike at a sample point inside a data bit is rejected by the majority vote.
- P=32, PAR_EN=1, PAR_TYP=1, back-to-back 0x55 then 0xAA with no idle gap -> two data_valid pulses 352 cycles apart with the correct data.
- Assert RST at mid-data of a frame, release, then send 0x81 at P=8 -> no strobes from the aborted frame; P_DATA = 0x81 after the new frame.

Source files
------------

// File: rtl/uart_rx_if.sv
// Interface between the RX pad/config side and the uart_rx_core receiver.
// data_valid is a one-cycle strobe with no back-pressure. P_DATA holds the last good word until the next good frame.
interface uart_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      data_valid;
    logic                      par_err;
    logic                      stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: majority-vote bit recovery, LSB-first deserialise, parity/stop check.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic       CLK,
    input  logic       RST,
    uart_rx_if.slave   bus,
    output logic [2:0] state_dbg
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]             BIT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic rx;
`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], bus.RX_IN};
    end
    assign rx = sync_q[1];
`else
    assign rx = bus.RX_IN;
`endif

    logic [PRESCALE_WIDTH-1:0] edge_cnt, prescale_q, half;
    logic [CW-1:0]             bit_cnt;
    logic [2:0]                samp_q;
    logic [DATA_WIDTH-1:0]     shift_q, p_data_q;
    logic                      par_en_q, par_typ_q, par_err_int;
    logic                      dv_q, pe_q, se_q;
    logic                      last_edge, bit_val, start_edge, frame_done;

    assign half      = prescale_q >> 1;
    assign last_edge = (edge_cnt == prescale_q - ONE);
    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        start_edge = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_nxt  = START;
                    start_edge = 1'b1;
                end
            end
            START:  if (last_edge) state_nxt = bit_val ? IDLE : DATA;
            DATA:   if (last_edge && bit_cnt == BIT_LAST) state_nxt = par_en_q ? PARITY : STOP;
            PARITY: if (last_edge) state_nxt = STOP;
            STOP: begin
                if (last_edge) begin
                    frame_done = 1'b1;
                    // A low line at the end of stop is already the next start bit.
                    if (!rx) begin
                        state_nxt  = START;
                        start_edge = 1'b1;
                    end else begin
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt    <= '0;
            prescale_q  <= '0;
            bit_cnt     <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            p_data_q    <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            par_err_int <= 1'b0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            if (start_edge) begin
                prescale_q  <= bus.PRESCALE;
                par_en_q    <= bus.PAR_EN;
                par_typ_q   <= bus.PAR_TYP;
                par_err_int <= 1'b0;
                bit_cnt     <= '0;
            end
            // From IDLE the detection cycle itself is edge 0; from STOP the next cycle is edge 0.
            if (state == IDLE)  edge_cnt <= start_edge ? ONE : '0;
            else if (last_edge) edge_cnt <= '0;
            else                edge_cnt <= edge_cnt + ONE;
            if (state != IDLE) begin
                if (edge_cnt == half - ONE) samp_q[0] <= rx;
                if (edge_cnt == half)       samp_q[1] <= rx;
                if (edge_cnt == half + ONE) samp_q[2] <= rx;
            end
            if (state == DATA && last_edge) begin
                shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (state == PARITY && last_edge)
                par_err_int <= bit_val ^ (^shift_q) ^ par_typ_q;
            if (frame_done) begin
                dv_q <= !par_err_int && bit_val;
                pe_q <= par_err_int;
                se_q <= !bit_val;
                if (!par_err_int && bit_val) p_data_q <= shift_q;
            end
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = pe_q;
    assign bus.stp_err    = se_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame-level model predicts strobe cycle and contents, checked every cycle.
module tb_uart_rx_core;
`ifdef UART_RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
    } ev_t;

    logic       CLK;
    logic       RST;
    logic [2:0] state_dbg;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        exp_q[$];
    int         dv_times[$];
    logic [7:0] pdata_model = 8'h00;

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) uif ();

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(uif),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    function automatic int last_dv_gap(input int from);
        if (dv_times.size() == 0) return -1;
        return dv_times[dv_times.size()-1] - from;
    endfunction

    // model: a frame is good when parity (if present) balances and stop is 1
    task automatic expect_frame(input int start, input int p, input bit pen, input bit ptyp,
                                input logic [7:0] data, input bit par_bit, input bit stop_bit);
        ev_t e;
        bit  par_ok;
        par_ok = !pen || (((^data) ^ par_bit) == ptyp);
        e.cyc  = 32'(start + (10 + int'(pen)) * p + SL);
        e.dv   = par_ok && stop_bit;
        e.pe   = !par_ok;
        e.se   = !stop_bit;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // scoreboard: outputs compared every cycle after the active edge settles
    initial begin
        ev_t  e;
        logic exp_dv, exp_pe, exp_se;
        forever begin
            @(posedge CLK);
            #2;
            exp_dv = 1'b0;
            exp_pe = 1'b0;
            exp_se = 1'b0;
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event cyc=%0d expected_at=%0d", cyc, e.cyc);
            end
            if (exp_q.size() > 0 && int'(exp_q[0].cyc) == cyc) begin
                e = exp_q.pop_front();
                exp_dv = e.dv;
                exp_pe = e.pe;
                exp_se = e.se;
                if (e.dv) pdata_model = e.data;
            end
            checks++;
            if ({uif.data_valid, uif.par_err, uif.stp_err} !== {exp_dv, exp_pe, exp_se} ||
                uif.P_DATA !== pdata_model) begin
                failures++;
                $display("FAIL cycle_check cyc=%0d got dv/pe/se=%b%b%b p_data=%h want %b%b%b %h",
                         cyc, uif.data_valid, uif.par_err, uif.stp_err, uif.P_DATA,
                         exp_dv, exp_pe, exp_se, pdata_model);
            end
            if (uif.data_valid === 1'b1) dv_times.push_back(cyc);
        end
    end

    // driver tasks (entered and left on a falling edge)
    task automatic idle(input int n);
        uif.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] data,
                              input bit flip_par, input bit stop_bit, input int spike_bit,
                              input int abort_bits, output int start);
        logic bits[$];
        bit   par_bit;
        par_bit = (^data) ^ ptyp ^ flip_par;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        uif.PRESCALE = 6'(p);
        uif.PAR_EN   = pen;
        uif.PAR_TYP  = ptyp;
        start = cyc;
        if (abort_bits == 0) expect_frame(start, p, pen, ptyp, data, par_bit, stop_bit);
        for (int k = 0; k < bits.size(); k++) begin
            if (abort_bits != 0 && k == abort_bits) return;
            for (int e = 0; e < p; e++) begin
                uif.RX_IN = (k == spike_bit + 1 && e == p / 2) ? ~bits[k] : bits[k];
                @(negedge CLK);
            end
            if (k == 0) begin
                // config changes after capture must not affect the frame in flight
                uif.PRESCALE = (p == 8) ? 6'd16 : 6'd8;
                uif.PAR_EN   = ~pen;
                uif.PAR_TYP  = ~ptyp;
            end
        end
    endtask

    initial begin
        int s, s2, n0;
        RST          = 1'b1;
        uif.RX_IN    = 1'b1;
        uif.PRESCALE = 6'd8;
        uif.PAR_EN   = 1'b0;
        uif.PAR_TYP  = 1'b0;
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        chk("reset_p_data", int'(uif.P_DATA), 0);

        // P=8 no parity, 0xA5
        n0 = dv_times.size();
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 0, s);
        idle(30);
        chk("t1_dv_count", dv_times.size() - n0, 1);
        chk("t1_latency", last_dv_gap(s), 80 + SL);
        chk("t1_p_data", int'(uif.P_DATA), 8'hA5);

        // P=16 even parity, good then bad parity bit
        n0 = dv_times.size();
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 0, s);
        idle(30);
        chk("t2_latency", last_dv_gap(s), 176 + SL);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 0, s);
        idle(30);
        chk("t2_dv_count", dv_times.size() - n0, 1);
        chk("t2_p_data_held", int'(uif.P_DATA), 8'h3C);

        // P=8 stop bit 0
        send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, -1, 0, s);
        idle(40);
        chk("t3_p_data_held", int'(uif.P_DATA), 8'h3C);

        // short low glitch, then a one-cycle spike inside data bit 3
        n0 = dv_times.size();
        uif.PRESCALE = 6'd16;
        uif.RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        idle(400);
        chk("t4_glitch_no_dv", dv_times.size() - n0, 0);
        send_frame(16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 3, 0, s);
        idle(30);
        chk("t4_spike_p_data", int'(uif.P_DATA), 8'hFF);

        // P=32 odd parity, back-to-back
        n0 = dv_times.size();
        send_frame(32, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, -1, 0, s);
        send_frame(32, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, -1, 0, s2);
        idle(40);
        chk("t5_dv_count", dv_times.size() - n0, 2);
        if (dv_times.size() >= 2)
            chk("t5_gap", dv_times[dv_times.size()-1] - dv_times[dv_times.size()-2], 352);
        chk("t5_p_data", int'(uif.P_DATA), 8'hAA);

        // break: line held low gives stp_err once per frame time
        uif.PRESCALE = 6'd8;
        uif.PAR_EN   = 1'b0;
        uif.PAR_TYP  = 1'b0;
        s = cyc;
        uif.RX_IN = 1'b0;
        expect_frame(s, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        expect_frame(s + 80, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        while (cyc < s + 161) @(negedge CLK);
        idle(60);

        // reset mid-frame, then a clean 0x81
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, 5, s);
        RST = 1'b0;
        exp_q.delete();
        pdata_model = 8'h00;
        repeat (3) @(negedge CLK);
        uif.RX_IN = 1'b1;
        RST = 1'b1;
        idle(20);
        chk("t6_p_data_cleared", int'(uif.P_DATA), 0);
        send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 0, s);
        idle(30);
        chk("t6_p_data", int'(uif.P_DATA), 8'h81);

        chk("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
